// File: rtl/lookup_mult_pkg.sv
// Shared constants, the stage-1 pipeline record and the nibble-product
// helper used to fill the lookup tables of lookup_multiplier.
package lookup_mult_pkg;

  localparam int OP_W   = 8;
  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;

  // Operand magnitudes plus the sign the final product must take.
  typedef struct packed {
    logic [OP_W-1:0] mag_a;
    logic [OP_W-1:0] mag_b;
    logic            neg;
  } stage1_t;

  // Shift-and-add 4x4 product; only used to build constant table contents.
  function automatic logic [2*NIB_W-1:0] nib_mul(input logic [NIB_W-1:0] x,
                                                 input logic [NIB_W-1:0] y);
    logic [2*NIB_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NIB_W; i++) begin
      if (y[i]) acc = acc + ({{NIB_W{1'b0}}, x} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/nibble_mul_lut.sv
// Combinational 256 x 8-bit ROM: 4-bit x 4-bit unsigned product.
// The table is a constant, so synthesis folds it into LUT logic.
module nibble_mul_lut
  import lookup_mult_pkg::*;
(
  input  logic [NIB_W-1:0]   x,
  input  logic [NIB_W-1:0]   y,
  output logic [2*NIB_W-1:0] prod
);

  logic [2*NIB_W-1:0] rom [256];

  // One table entry per {x,y} address.
  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    localparam logic [7:0] IDX = 8'(gi);
    assign rom[gi] = nib_mul(IDX[7:4], IDX[3:0]);
  end

  assign prod = rom[{x, y}];

endmodule

// File: rtl/lookup_multiplier.sv
// Two-stage 8x8 signed/unsigned multiplier built from four 4x4 nibble
// lookup tables (no '*' operator).
// Stage 1 registers operand magnitudes and the result sign; stage 2 sums
// the nibble products, applies the sign and registers p.
// Optional macro LUT_MULT_ZERO_FLAG_EN adds the output z (p == 0), aligned
// with p.
module lookup_multiplier
  import lookup_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              sgnd,
  output logic [PROD_W-1:0] p
`ifdef LUT_MULT_ZERO_FLAG_EN
  ,
  output logic              z
`endif
);

  stage1_t s1_next;
  stage1_t s1_reg;

  // Sign/magnitude split; -128 maps to 8'h80, which is its own magnitude.
  always_comb begin
    s1_next       = '0;
    s1_next.neg   = sgnd & (a[OP_W-1] ^ b[OP_W-1]);
    s1_next.mag_a = (sgnd & a[OP_W-1]) ? (~a + 8'd1) : a;
    s1_next.mag_b = (sgnd & b[OP_W-1]) ? (~b + 8'd1) : b;
  end

  // Stage-1 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_reg <= '0;
    else        s1_reg <= s1_next;
  end

  // Nibble products: index {a_hi_sel, b_hi_sel} -> 0=LL, 1=LH, 2=HL, 3=HH.
  logic [2*NIB_W-1:0] nib_prod [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lut
    localparam logic [1:0] SEL = 2'(gi);
    nibble_mul_lut u_lut (
      .x    (SEL[1] ? s1_reg.mag_a[7:4] : s1_reg.mag_a[3:0]),
      .y    (SEL[0] ? s1_reg.mag_b[7:4] : s1_reg.mag_b[3:0]),
      .prod (nib_prod[gi])
    );
  end

  logic [PROD_W-1:0] cross_sum;
  logic [PROD_W-1:0] mag_sum;
  logic [PROD_W-1:0] result_next;

  // Adder tree on the unsigned magnitude, then conditional two's-complement negate.
  always_comb begin
    cross_sum   = {8'd0, nib_prod[1]} + {8'd0, nib_prod[2]};
    mag_sum     = {8'd0, nib_prod[0]} + (cross_sum << 4) + ({8'd0, nib_prod[3]} << 8);
    result_next = s1_reg.neg ? (~mag_sum + 16'd1) : mag_sum;
  end

  // Stage-2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= result_next;
  end

`ifdef LUT_MULT_ZERO_FLAG_EN
  // Zero flag registered alongside p; a cleared p reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z <= 1'b1;
    else        z <= (result_next == '0);
  end
`endif

endmodule

// File: tb/tb_lookup_multiplier.sv
// Scoreboard bench for lookup_multiplier: expected products are pushed as
// operands are driven and popped when the pipeline delivers them.
module tb_lookup_multiplier;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sgnd;
  logic [15:0] p;
`ifdef LUT_MULT_ZERO_FLAG_EN
  logic        z;
`endif

  lookup_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sgnd  (sgnd),
    .p     (p)
`ifdef LUT_MULT_ZERO_FLAG_EN
    ,
    .z     (z)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q [$];
  logic [1:0]  vpipe;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
    int r;
    if (s) r = $signed(x) * $signed(y);
    else   r = int'(x) * int'(y);
    return r[15:0];
  endfunction

  // Drive one operand pair (or an idle slot), advance one edge, then compare
  // any result that has had two edges to travel through the pipeline.
  task automatic step(input logic [7:0] x, input logic [7:0] y, input logic s,
                      input logic valid, input string tag);
    logic [15:0] e;
    a    = x;
    b    = y;
    sgnd = s;
    if (valid) exp_q.push_back(ref_mul(x, y, s));
    @(posedge clk);
    vpipe = {vpipe[0], valid};
    #1;
    if (vpipe[1]) begin
      if (exp_q.size() == 0) begin
        check_val({tag, "_queue_empty"}, 16'd0, 16'd1);
      end else begin
        e = exp_q.pop_front();
        check_val(tag, p, e);
`ifdef LUT_MULT_ZERO_FLAG_EN
        check_val({tag, "_z"}, {15'd0, z}, {15'd0, (e == 16'd0)});
`endif
        $display("op %s p=%h exp=%h", tag, p, e);
      end
    end
  endtask

  task automatic flush();
    step(8'd0, 8'd0, 1'b0, 1'b0, "flush");
    step(8'd0, 8'd0, 1'b0, 1'b0, "flush");
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    sgnd  = 1'b0;
    vpipe = 2'b00;
    #12;
    check_val("reset_p", p, 16'h0000);
`ifdef LUT_MULT_ZERO_FLAG_EN
    check_val("reset_z", {15'd0, z}, 16'd1);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Corners
    step(8'd0,   8'd0,   1'b0, 1'b1, "zero_zero");
    step(8'd255, 8'd255, 1'b0, 1'b1, "u255x255");
    step(8'h80,  8'h80,  1'b1, 1'b1, "s_m128xm128");
    step(8'h80,  8'h7F,  1'b1, 1'b1, "s_m128x127");
    step(8'hFF,  8'hFF,  1'b1, 1'b1, "s_m1xm1");
    step(8'd0,   8'd77,  1'b0, 1'b1, "zero_77");
    step(8'd3,   8'd5,   1'b0, 1'b1, "u3x5");
    step(8'h7F,  8'h7F,  1'b1, 1'b1, "s127x127");
    step(8'h00,  8'h80,  1'b1, 1'b1, "s0xm128");
    step(8'hF0,  8'h0F,  1'b0, 1'b1, "u_f0x0f");
    flush();

    // Mode interleave on a=b=FF
    for (int i = 0; i < 8; i++) step(8'hFF, 8'hFF, i[0], 1'b1, "interleave");
    flush();

    // Full sweep of a against a few fixed b, both modes
    for (int i = 0; i < 256; i++) begin
      step(8'(i), 8'h80, 1'b1, 1'b1, "sweep_s_b80");
      step(8'(i), 8'hFF, 1'b0, 1'b1, "sweep_u_bff");
      step(8'hA5, 8'(i), 1'b1, 1'b1, "sweep_s_a5");
    end
    flush();

    // Random mixed-mode stream
    for (int i = 0; i < 3000; i++)
      step(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "random");
    flush();

    // Asynchronous reset mid-stream, between edges
    step(8'd200, 8'd199, 1'b0, 1'b1, "pre_rst");
    step(8'd123, 8'd45,  1'b0, 1'b1, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_p", p, 16'h0000);
`ifdef LUT_MULT_ZERO_FLAG_EN
    check_val("async_rst_z", {15'd0, z}, 16'd1);
`endif
    exp_q.delete();
    vpipe = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_hold_p", p, 16'h0000);
    rst_n = 1'b1;
    step(8'd17, 8'd19, 1'b0, 1'b1, "post_rst");
    step(8'h9C, 8'h33, 1'b1, 1'b1, "post_rst");
    step(8'd3,  8'd5,  1'b0, 1'b1, "post_rst");
    flush();

    check_val("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
